// File: rtl/busy_arbiter_if.sv
// Request/grant bundle between the requesters and the busy-timer arbiter.
// The arbiter uses the slave view; the requester side uses the master view.
interface busy_arbiter_if #(
    parameter int NREQ = 4
) ();
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0] i_req;      // level request per requester
    logic [NREQ-1:0] o_grant;    // one-hot owner of the shared timer
    logic            o_busy;     // shared timer is counting
    logic            o_done;     // one-cycle completion pulse
    logic            o_abort;    // qualifies o_done: run ended early
    logic [IDW-1:0]  o_done_id;  // requester that finished, valid with o_done

    modport master (
        output i_req,
        input  o_grant,
        input  o_busy,
        input  o_done,
        input  o_abort,
        input  o_done_id
    );

    modport slave (
        input  i_req,
        output o_grant,
        output o_busy,
        output o_done,
        output o_abort,
        output o_done_id
    );
endinterface

// File: rtl/busy_arbiter.sv
// Round-robin arbiter for one shared busy timer. A winner owns the timer for
// MAX_AMOUNT cycles (or until it drops its request), then a one-cycle DONE
// reports completion before the next arbitration in IDLE.
module busy_arbiter #(
    parameter int          NREQ       = 4,
    parameter logic [15:0] MAX_AMOUNT = 16'd1000
) (
    input  logic          i_clk,
    input  logic          i_reset,
    busy_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // NOTE: declaration initialisers give power-up values equal to the reset
    // values; they are not initial blocks and are honoured by FPGA synthesis.
    state_t          r_state   = ST_IDLE;
    logic [15:0]     r_counter = '0;
    // The current winner doubles as last_winner: both are written together on
    // grant, and the round-robin search only runs in IDLE.
    logic [IDW-1:0]  r_winner  = IDW'(NREQ - 1);
    logic [NREQ-1:0] r_grant   = '0;
    logic            r_busy    = 1'b0;
    logic            r_done    = 1'b0;
    logic            r_abort   = 1'b0;
    logic [IDW-1:0]  r_done_id = '0;

    state_t          w_state_nxt;
    logic [15:0]     w_counter_nxt;
    logic [IDW-1:0]  w_winner_nxt;
    logic [NREQ-1:0] w_grant_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;
    logic            w_abort_nxt;
    logic [IDW-1:0]  w_done_id_nxt;

    logic            w_pick_valid;
    logic [IDW-1:0]  w_pick;
    logic [IDW-1:0]  w_idx;
    logic            w_owner_req;

    assign w_owner_req = bus.i_req[r_winner];

    // Round-robin search: first active request strictly after the last winner,
    // wrapping around, so the last winner is considered last.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so
        // no path leaves it unassigned, which would infer a latch.
        w_pick_valid = 1'b0;
        w_pick       = r_winner;
        w_idx        = r_winner;
        for (int i = 1; i <= NREQ; i++) begin
            w_idx = IDW'((int'(r_winner) + i) % NREQ);
            if (!w_pick_valid && bus.i_req[w_idx]) begin
                w_pick_valid = 1'b1;
                w_pick       = w_idx;
            end
        end
    end

    // Next-state and next-output logic; outputs are registered from these.
    always_comb begin
        w_state_nxt   = r_state;
        w_counter_nxt = r_counter;
        w_winner_nxt  = r_winner;
        w_grant_nxt   = '0;
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        w_abort_nxt   = 1'b0;
        w_done_id_nxt = r_done_id;

        unique case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt   = ST_RUN;
                    w_counter_nxt = MAX_AMOUNT - 16'd1;
                    w_winner_nxt  = w_pick;
                    w_grant_nxt   = NREQ'(1) << w_pick;
                    w_busy_nxt    = 1'b1;
                end
            end

            ST_RUN: begin
                if (!w_owner_req) begin
                    // Owner let go: abort wins even if the count just expired.
                    w_state_nxt   = ST_DONE;
                    w_done_nxt    = 1'b1;
                    w_abort_nxt   = 1'b1;
                    w_done_id_nxt = r_winner;
                end else if (r_counter == 16'd0) begin
                    w_state_nxt   = ST_DONE;
                    w_done_nxt    = 1'b1;
                    w_done_id_nxt = r_winner;
                end else begin
                    w_counter_nxt = r_counter - 16'd1;
                    w_grant_nxt   = r_grant;
                    w_busy_nxt    = 1'b1;
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; synchronous reset discards any run silently.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_counter <= '0;
            r_winner  <= IDW'(NREQ - 1);
            r_grant   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_abort   <= 1'b0;
            r_done_id <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_counter <= w_counter_nxt;
            r_winner  <= w_winner_nxt;
            r_grant   <= w_grant_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_abort   <= w_abort_nxt;
            r_done_id <= w_done_id_nxt;
        end
    end

    assign bus.o_grant   = r_grant;
    assign bus.o_busy    = r_busy;
    assign bus.o_done    = r_done;
    assign bus.o_abort   = r_abort;
    assign bus.o_done_id = r_done_id;
endmodule

// File: tb/tb_busy_arbiter.sv
// Bench for busy_arbiter: two instances (MAX_AMOUNT=4 and MAX_AMOUNT=1) share
// a clock; a behavioural model predicts each cycle's outputs into a queue that
// is drained and compared on the falling edge.
module tb_busy_arbiter;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_DONE = 2;

    typedef struct {
        logic [3:0] grant;
        logic       busy;
        logic       done;
        logic       abort;
        logic [1:0] id;
        logic       chk_id;
    } exp_t;

    logic clk = 1'b0;
    logic rst4 = 1'b1;
    logic rst1 = 1'b1;
    logic sel  = 1'b0;   // 0: MAX_AMOUNT=4 instance, 1: MAX_AMOUNT=1 instance

    always #5 clk = ~clk;

    busy_arbiter_if #(.NREQ(4)) b4 ();
    busy_arbiter_if #(.NREQ(4)) b1 ();

    busy_arbiter #(.NREQ(4), .MAX_AMOUNT(16'd4)) dut4 (
        .i_clk   (clk),
        .i_reset (rst4),
        .bus     (b4)
    );

    busy_arbiter #(.NREQ(4), .MAX_AMOUNT(16'd1)) dut1 (
        .i_clk   (clk),
        .i_reset (rst1),
        .bus     (b1)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    exp_t sb[$];
    int   grant_log[$];
    int   grant_cyc[$];
    logic prev_busy = 1'b0;

    // Behavioural model state
    int         m_state;
    int         m_cnt;
    int         m_last;
    int         m_win;
    int         m_max = 4;
    logic [3:0] m_grant;
    logic       m_busy, m_done, m_abort;
    logic [1:0] m_id;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE;
        m_cnt   = 0;
        m_last  = 3;
        m_win   = 3;
        m_grant = 4'b0000;
        m_busy  = 1'b0;
        m_done  = 1'b0;
        m_abort = 1'b0;
        m_id    = 2'd0;
    endtask

    task automatic model_finish(input logic abort);
        m_state = S_DONE;
        m_grant = 4'b0000;
        m_busy  = 1'b0;
        m_done  = 1'b1;
        m_abort = abort;
        m_id    = 2'(m_win);
    endtask

    task automatic model_step(input logic [3:0] req, input logic rst);
        bit found;
        int idx;
        exp_t e;
        if (rst) begin
            model_reset();
        end else begin
            case (m_state)
                S_IDLE: begin
                    m_done = 1'b0;
                    m_abort = 1'b0;
                    found = 1'b0;
                    for (int i = 1; i <= 4; i++) begin
                        idx = (m_last + i) % 4;
                        if (!found && req[idx]) begin
                            found = 1'b1;
                            m_win = idx;
                        end
                    end
                    if (found) begin
                        m_state = S_RUN;
                        m_last  = m_win;
                        m_cnt   = m_max - 1;
                        m_grant = 4'b0001 << m_win;
                        m_busy  = 1'b1;
                    end
                end
                S_RUN: begin
                    if (!req[m_win])    model_finish(1'b1);
                    else if (m_cnt == 0) model_finish(1'b0);
                    else                m_cnt = m_cnt - 1;
                end
                default: begin
                    m_state = S_IDLE;
                    m_done  = 1'b0;
                    m_abort = 1'b0;
                end
            endcase
        end
        e.grant  = m_grant;
        e.busy   = m_busy;
        e.done   = m_done;
        e.abort  = m_abort;
        e.id     = m_id;
        e.chk_id = m_done | rst;
        sb.push_back(e);
    endtask

    // Called on a falling edge: compare this cycle's outputs, drive the next
    // inputs, predict the result of the coming rising edge.
    task automatic step(input logic [3:0] req, input logic rst);
        exp_t e;
        logic [3:0] g;
        logic bz, dn, ab;
        logic [1:0] id;
        g  = sel ? b1.o_grant   : b4.o_grant;
        bz = sel ? b1.o_busy    : b4.o_busy;
        dn = sel ? b1.o_done    : b4.o_done;
        ab = sel ? b1.o_abort   : b4.o_abort;
        id = sel ? b1.o_done_id : b4.o_done_id;
        e = sb.pop_front();
        check("grant", g, e.grant);
        check("busy", bz, e.busy);
        check("done", dn, e.done);
        check("abort", ab, e.abort);
        if (e.chk_id) check("done_id", id, e.id);
        if (bz && !prev_busy) begin
            for (int i = 0; i < 4; i++) if (g[i]) grant_log.push_back(i);
            grant_cyc.push_back(cyc);
        end
        prev_busy = bz;
        if (sel) begin
            b1.i_req = req; rst1 = rst;
            b4.i_req = 4'b0000; rst4 = 1'b1;
        end else begin
            b4.i_req = req; rst4 = rst;
            b1.i_req = 4'b0000; rst1 = 1'b1;
        end
        model_step(req, rst);
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic repeat_step(input logic [3:0] req, input int n);
        for (int i = 0; i < n; i++) step(req, 1'b0);
    endtask

    // Formal-style properties on the MAX_AMOUNT=4 instance
    a_grant_shape: assert property (@(posedge clk) disable iff (rst4)
        $countones(b4.o_grant) == int'(b4.o_busy))
        else $error("p_grant_shape grant=%b busy=%b", b4.o_grant, b4.o_busy);

    a_abort_prio: assert property (@(posedge clk) disable iff (rst4)
        (b4.o_busy && !(|(b4.i_req & b4.o_grant))) |=> (b4.o_done && b4.o_abort && !b4.o_busy))
        else $error("p_abort_prio done=%b abort=%b", b4.o_done, b4.o_abort);

    a_cnt_dec: assert property (@(posedge clk) disable iff (rst4)
        (b4.o_busy && $past(b4.o_busy)) |-> (dut4.r_counter == $past(dut4.r_counter) - 16'd1))
        else $error("p_cnt_dec counter=%0d", dut4.r_counter);

    a_done_quiet: assert property (@(posedge clk) disable iff (rst4)
        !b4.o_done |-> !b4.o_abort)
        else $error("p_done_quiet abort without done");

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        b4.i_req = 4'b0000;
        b1.i_req = 4'b0000;
        model_reset();
        model_step(4'b0000, 1'b1);   // power-up / held-reset values
        @(negedge clk);

        // Reset, then single requester 2: 4 RUN cycles, DONE id=2, back to IDLE
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        repeat_step(4'b0100, 6);
        repeat_step(4'b0000, 3);

        // All request continuously: round-robin 0,1,2,3,0 spaced by 6 cycles
        step(4'b0000, 1'b1);
        grant_log.delete();
        grant_cyc.delete();
        repeat_step(4'b1111, 34);
        check("rr_grants_seen", grant_log.size() >= 5, 1);
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            check("rr_order", grant_log[i], i % 4);
        for (int i = 1; i < 5 && i < grant_cyc.size(); i++)
            check("rr_gap", grant_cyc[i] - grant_cyc[i-1], 6);

        // Winner 1 drops its request in the 2nd RUN cycle -> abort, id=1
        step(4'b0000, 1'b1);
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b0);
        step(4'b0000, 1'b0);
        repeat_step(4'b0000, 3);

        // Non-winner 1 held through an aborted run of 0 is served afterwards
        step(4'b0000, 1'b1);
        repeat_step(4'b0011, 2);
        repeat_step(4'b0010, 8);
        repeat_step(4'b0000, 2);

        // Reset in the 3rd RUN cycle: silent discard, then requester 3 wins
        step(4'b0000, 1'b1);
        repeat_step(4'b0001, 3);
        step(4'b0001, 1'b1);
        repeat_step(4'b1000, 8);
        repeat_step(4'b1001, 8);
        repeat_step(4'b0000, 2);

        // Random requests with occasional reset
        for (int i = 0; i < 300; i++)
            step(4'($urandom_range(0, 15)), $urandom_range(0, 39) == 0);
        step(4'b0000, 1'b1);

        // MAX_AMOUNT=1 instance: one RUN cycle, DONE, IDLE, re-grant to 0
        sel   = 1'b1;
        m_max = 1;
        step(4'b0000, 1'b1);
        grant_log.delete();
        grant_cyc.delete();
        prev_busy = 1'b0;
        repeat_step(4'b0001, 9);
        step(4'b0000, 1'b0);
        check("m1_grants_seen", grant_cyc.size() >= 3, 1);
        for (int i = 1; i < 3 && i < grant_cyc.size(); i++)
            check("m1_regrant_gap", grant_cyc[i] - grant_cyc[i-1], 3);
        for (int i = 0; i < 40; i++)
            step(4'($urandom_range(0, 15)), 1'b0);
        step(4'b0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/busy_arbiter.md
BUSY_ARBITER -- requirements
Module: busy_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning the number of requesters (legal range 2..8).
REQ-002 SHALL have parameter MAX_AMOUNT, 16 bits, default 1000, meaning busy cycles per grant; legal range 1..65535.
REQ-003 SHALL have port i_clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-004 SHALL have port i_reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port i_req, input, NREQ bits: level request per requester.
REQ-006 SHALL have port o_grant, output, NREQ bits: one-hot owner of the shared timer, registered.
REQ-007 SHALL have port o_busy, output, 1 bit: high while the shared timer is counting (state RUN).
REQ-008 SHALL have port o_done, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have port o_abort, output, 1 bit: qualifies o_done; high when the run ended early.
REQ-010 SHALL have port o_done_id, output, clog2(NREQ) bits: index of the requester that finished; valid only when o_done=1.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-012 SHALL hold a 16-bit down-counter, modified only in RUN and on grant; it never wraps below 0.
REQ-013 IDLE, i_req==0: SHALL remain in IDLE with outputs deasserted.
REQ-014 IDLE, i_req!=0: SHALL select one winner round-robin, searching upward (with wrap) from last_winner+1.
REQ-015 On that edge SHALL load counter=MAX_AMOUNT-1, set o_grant to the winner's one-hot bit, record winner and last_winner, and enter RUN.
REQ-016 Grant latency SHALL be exactly 1 cycle: request sampled high at edge k -> o_grant/o_busy high after edge k.
REQ-017 RUN, i_req[winner]=1 and counter!=0: SHALL decrement counter by 1.
REQ-018 RUN, i_req[winner]=1 and counter==0: SHALL enter DONE with o_abort=0.
REQ-019 RUN SHALL therefore last exactly MAX_AMOUNT cycles when not aborted, including MAX_AMOUNT=1 (one RUN cycle).
REQ-020 RUN, i_req[winner]=0: SHALL enter DONE with o_abort=1 regardless of counter value; this abort takes priority over the counter==0 completion on the same edge.
REQ-021 DONE: SHALL assert o_done=1 and o_done_id=winner, drive o_grant=0 and o_busy=0, and enter IDLE unconditionally after one cycle.
REQ-022 Requests from non-winners during RUN or DONE SHALL be ignored, not lost; they are served if still high in IDLE.
REQ-023 The minimum gap between two grants SHALL be 2 cycles (DONE plus IDLE).
REQ-024 Round-robin SHALL be fair: a requester held continuously high SHALL be granted within NREQ grants.
REQ-025 o_grant SHALL be one-hot in RUN and zero otherwise; o_busy SHALL equal (state==RUN).
REQ-026 o_done and o_abort SHALL be zero outside DONE.

Reset
REQ-027 i_reset SHALL take priority over all other inputs and apply on the next edge.
REQ-028 On reset SHALL set state=IDLE, counter=0, o_grant=0, o_busy=0, o_done=0, o_abort=0, o_done_id=0, and last_winner=NREQ-1 (so requester 0 wins first).
REQ-029 Reset during RUN or DONE SHALL discard the run without any o_done pulse.
REQ-030 Power-up initial values SHALL match the reset values.

Verification
REQ-031 A bench SHALL check: NREQ=4, MAX_AMOUNT=4; i_req=0100 from cycle 1 -> o_grant=0100 and o_busy for cycles 2-5, o_done with id=2 and o_abort=0 at cycle 6, IDLE at cycle 7.
REQ-032 A bench SHALL check: i_req=1111 held after reset -> grant order 0,1,2,3,0 with 2 idle/done cycles between RUN periods.
REQ-033 A bench SHALL check: MAX_AMOUNT=4; winner 1 drops i_req in the 2nd RUN cycle -> DONE next cycle, o_done=1, o_abort=1, o_done_id=1.
REQ-034 A bench SHALL check: MAX_AMOUNT=1; i_req=0001 -> 1 RUN cycle, then o_done, then re-grant to 0 after IDLE if still requesting.
REQ-035 A bench SHALL check: i_reset asserted in the 3rd RUN cycle -> all outputs 0 next cycle, no o_done; i_req=1000 then wins first arbitration only if 0-2 are low.
REQ-036 A bench SHALL carry formal properties for REQ-025 and REQ-020, plus: in RUN the counter equals its past value minus 1 unless just loaded.
